// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one single-precision add/sub/mult datapath among N requesters.
// Results return through a fixed-latency pipeline tagged with the requester id.
module fp_unit_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [2*N-1:0]  req_op,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    output logic [N-1:0]    req_ready,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [31:0]     rsp_data,
    output logic            rsp_err,
    output logic [N-1:0]    rsp_done,
    output logic            busy
);
    localparam int PS = LAT - 1;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       seen;
        n    = 5'd0;
        seen = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            seen = seen | v[i];
            n    = seen ? n : n + 5'd1;
        end
        return n;
    endfunction

    // Exponent arrives as a signed 10-bit value; underflow flushes to zero, overflow saturates to inf.
    function automatic logic [31:0] fp_pack(input logic s, input logic [9:0] e, input logic [22:0] f);
        logic [31:0] r;
        if (e[9] || e == 10'd0) r = 32'd0;
        else if (e >= 10'd255) r = {s, 8'hFF, 23'd0};
        else r = {s, e[7:0], f};
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [23:0] mx, my, nrm;
        logic [7:0]  d;
        logic [24:0] s;
        logic [4:0]  lz;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        my  = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
        d   = x[30:23] - y[30:23];
        my  = (d > 8'd24) ? 24'd0 : (my >> d);
        s   = 25'd0;
        lz  = 5'd0;
        nrm = 24'd0;
        if (mx == 24'd0) begin
            r = 32'd0;
        end else if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[24]) r = fp_pack(x[31], {2'b00, x[30:23]} + 10'd1, s[23:1]);
            else r = fp_pack(x[31], {2'b00, x[30:23]}, s[22:0]);
        end else begin
            s   = {1'b0, mx} - {1'b0, my};
            lz  = lzc24(s[23:0]);
            nrm = s[23:0] << lz;
            if (s == 25'd0) r = 32'd0;
            else r = fp_pack(x[31], {2'b00, x[30:23]} - {5'd0, lz}, nrm[22:0]);
        end
        return r;
    endfunction

    // Only the top 17 fraction bits of each operand enter the 18x18 product.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [35:0] p;
        logic [9:0]  e;
        logic [31:0] r;
        p = {18'd0, 1'b1, a[22:6]} * {18'd0, 1'b1, b[22:6]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, p[35]};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) r = 32'd0;
        else if (p[35]) r = fp_pack(a[31] ^ b[31], e, p[34:12]);
        else r = fp_pack(a[31] ^ b[31], e, p[33:11]);
        return r;
    endfunction

    logic [N-1:0]   pending_r, elig_s, grant_s, done_s;
    logic [IDW-1:0] rr_ptr_r, grant_id_s, s0_id_r;
    logic           found_s, hit_s, s0_valid_r, core_err_s, busy_s;
    logic [1:0]     sel_op_s, s0_op_r;
    logic [31:0]    sel_a_s, sel_b_s, s0_a_r, s0_b_r, core_data_s;
    logic           p_valid_r [PS];
    logic [IDW-1:0] p_id_r    [PS];
    logic [31:0]    p_data_r  [PS];
    logic           p_err_r   [PS];
    logic [N-1:0]   p_done_r  [PS];

    assign elig_s = req_valid & ~pending_r;

    // Rotating priority: first pass covers indices at/after rr_ptr, second pass wraps from 0.
    always_comb begin
        grant_s    = {N{1'b0}};
        grant_id_s = {IDW{1'b0}};
        found_s    = 1'b0;
        hit_s      = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit_s      = ~found_s & elig_s[i] & (i >= int'(rr_ptr_r));
            grant_s[i] = grant_s[i] | hit_s;
            grant_id_s = hit_s ? IDW'(i) : grant_id_s;
            found_s    = found_s | hit_s;
        end
        for (int i = 0; i < N; i++) begin
            hit_s      = ~found_s & elig_s[i];
            grant_s[i] = grant_s[i] | hit_s;
            grant_id_s = hit_s ? IDW'(i) : grant_id_s;
            found_s    = found_s | hit_s;
        end
    end

    assign req_ready = reset ? {N{1'b0}} : grant_s;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_op_s = 2'd0;
        sel_a_s  = 32'd0;
        sel_b_s  = 32'd0;
        for (int i = 0; i < N; i++) begin
            sel_op_s = sel_op_s | (req_op[2*i +: 2] & {2{grant_s[i]}});
            sel_a_s  = sel_a_s | (req_a[32*i +: 32] & {32{grant_s[i]}});
            sel_b_s  = sel_b_s | (req_b[32*i +: 32] & {32{grant_s[i]}});
        end
    end

    // Issue register, pending bits and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid_r <= 1'b0;
            s0_op_r    <= 2'd0;
            s0_a_r     <= 32'd0;
            s0_b_r     <= 32'd0;
            s0_id_r    <= {IDW{1'b0}};
            rr_ptr_r   <= {IDW{1'b0}};
            pending_r  <= {N{1'b0}};
        end else begin
            s0_valid_r <= found_s;
            pending_r  <= (pending_r & ~rsp_done) | grant_s;
            if (found_s) begin
                s0_op_r  <= sel_op_s;
                s0_a_r   <= sel_a_s;
                s0_b_r   <= sel_b_s;
                s0_id_r  <= grant_id_s;
                rr_ptr_r <= (grant_id_s == IDW'(N-1)) ? {IDW{1'b0}} : grant_id_s + IDW'(1);
            end
        end
    end

    // Combinational FP core reading the issue register.
    always_comb begin
        core_err_s = 1'b0;
        case (s0_op_r)
            2'b00:   core_data_s = fp_add(s0_a_r, s0_b_r);
            2'b01:   core_data_s = fp_add(s0_a_r, {~s0_b_r[31], s0_b_r[30:0]});
            2'b10:   core_data_s = fp_mul(s0_a_r, s0_b_r);
            default: begin
                core_data_s = 32'd0;
                core_err_s  = 1'b1;
            end
        endcase
        for (int i = 0; i < N; i++) begin
            done_s[i] = s0_valid_r & (s0_id_r == IDW'(i));
        end
    end

    // Output stages; fields are zeroed when no result is travelling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PS; s++) begin
                p_valid_r[s] <= 1'b0;
                p_id_r[s]    <= {IDW{1'b0}};
                p_data_r[s]  <= 32'd0;
                p_err_r[s]   <= 1'b0;
                p_done_r[s]  <= {N{1'b0}};
            end
        end else begin
            p_valid_r[0] <= s0_valid_r;
            p_id_r[0]    <= s0_valid_r ? s0_id_r : {IDW{1'b0}};
            p_data_r[0]  <= s0_valid_r ? core_data_s : 32'd0;
            p_err_r[0]   <= s0_valid_r & core_err_s;
            p_done_r[0]  <= done_s;
            for (int s = 1; s < PS; s++) begin
                p_valid_r[s] <= p_valid_r[s-1];
                p_id_r[s]    <= p_id_r[s-1];
                p_data_r[s]  <= p_data_r[s-1];
                p_err_r[s]   <= p_err_r[s-1];
                p_done_r[s]  <= p_done_r[s-1];
            end
        end
    end

    // Activity flag over every pipeline valid bit and pending bit.
    always_comb begin
        busy_s = s0_valid_r | (|pending_r);
        for (int s = 0; s < PS; s++) begin
            busy_s = busy_s | p_valid_r[s];
        end
    end

    assign busy      = busy_s;
    assign rsp_valid = p_valid_r[PS-1];
    assign rsp_id    = p_id_r[PS-1];
    assign rsp_data  = p_data_r[PS-1];
    assign rsp_err   = p_err_r[PS-1];
    assign rsp_done  = p_done_r[PS-1];

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: directed scenarios then random traffic, checked against a
// time-based model (per-requester free cycle, FIFO of expected responses, integer arithmetic).
module tb_fp_unit_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready, rsp_done;
    logic            rsp_valid, rsp_err, busy;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;

    fp_unit_arbiter #(.N(N), .IDW(IDW), .LAT(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_done(rsp_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t       exp_q[$];
    int         free_at [N];
    int         ptr, cyc, checks, failures;
    logic       rv [N];
    logic [1:0] rop [N];
    int         ra [N];
    int         rb [N];

    // Exact IEEE single encoding of a small integer.
    function automatic logic [31:0] enc(input int v);
        int m, p;
        logic [31:0] r;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
        r        = 32'd0;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int rnd_val();
        int m;
        m = int'($urandom_range(1, 255));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    function automatic int model_grant();
        int g;
        g = -1;
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (g < 0 && rv[i] && cyc >= free_at[i]) g = i;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = rv[i];
            req_op[2*i +: 2]  = rop[i];
            req_a[32*i +: 32] = enc(ra[i]);
            req_b[32*i +: 32] = enc(rb[i]);
        end
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int          g;
        logic [N-1:0] exp_ready, exp_done;
        logic        ev, exp_busy;
        rsp_t        r, n;
        drive();
        @(negedge clk);
        g         = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        ev = !reset && exp_q.size() > 0 && exp_q[0].due == cyc;
        r  = '{due: 0, id: 0, data: 32'd0, err: 1'b0};
        if (ev) r = exp_q[0];
        exp_done = '0;
        if (ev) exp_done[r.id] = 1'b1;
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++) if (!reset && cyc < free_at[i]) exp_busy = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_id", 32'(rsp_id), 32'(r.id));
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_done", 32'(rsp_done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < N; i++) free_at[i] = 0;
            ptr = 0;
        end else begin
            if (ev) void'(exp_q.pop_front());
            if (g >= 0) begin
                n.due = cyc + LAT;
                n.id  = g;
                n.err = 1'b0;
                case (rop[g])
                    2'd0:    n.data = enc(ra[g] + rb[g]);
                    2'd1:    n.data = enc(ra[g] - rb[g]);
                    2'd2:    n.data = enc(ra[g] * rb[g]);
                    default: begin
                        n.data = 32'd0;
                        n.err  = 1'b1;
                    end
                endcase
                exp_q.push_back(n);
                free_at[g] = cyc + LAT + 1;
                ptr        = (g + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        ptr      = 0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; rop[i] = 2'd0; ra[i] = 1; rb[i] = 1; free_at[i] = 0;
        end
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        idle(1);

        // single add 1.0 + 2.0, operand changed after handshake
        rv[0] = 1'b1; rop[0] = 2'd0; ra[0] = 1; rb[0] = 2;
        cycle();
        rv[0] = 1'b0; ra[0] = 77; rb[0] = -9;
        cycle(); cycle(); cycle(); cycle();

        // bring pointer back to 0, then all four multiply 2.0 * 3.0
        rv[3] = 1'b1; rop[3] = 2'd0; cycle();
        idle(4);
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; rop[i] = 2'd2; ra[i] = 2; rb[i] = 3;
        end
        for (int k = 0; k < 10; k++) cycle();
        idle(4);

        // pointer to 2, then requesters 1 and 3 held high
        rv[1] = 1'b1; rop[1] = 2'd0; ra[1] = 4; rb[1] = 5; cycle();
        idle(4);
        rv[1] = 1'b1; rv[3] = 1'b1; rop[3] = 2'd1; ra[3] = 9; rb[3] = 20;
        for (int k = 0; k < 10; k++) cycle();
        idle(4);

        // sub 5.0 - 1.0, then reserved op, then immediate regrant
        rv[2] = 1'b1; rop[2] = 2'd1; ra[2] = 5; rb[2] = 1; cycle();
        idle(4);
        rv[2] = 1'b1; rop[2] = 2'd3; cycle();
        rv[2] = 1'b0; cycle(); cycle(); cycle();
        rv[2] = 1'b1; rop[2] = 2'd0; ra[2] = -7; rb[2] = 7; cycle();
        idle(4);

        // reset while an op is in flight, request held throughout
        rv[1] = 1'b1; rop[1] = 2'd2; ra[1] = 3; rb[1] = 4; cycle();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        idle(5);

        // random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                rv[i]  = ($urandom_range(0, 99) < 60);
                rop[i] = 2'($urandom_range(0, 3));
                ra[i]  = rnd_val();
                rb[i]  = rnd_val();
            end
            reset = (c % 97 == 50);
            cycle();
        end
        reset = 1'b0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
